// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage ahead of the microcoded control unit. Holds the
//               PC, runs a req/gnt/rvalid read against instruction memory,
//               latches the returned word into IR and slices the RV32 fields.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        pc_wr_en,
    input  logic [31:0] pc_wr_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        ir_valid,
    output logic        fetch_err,
    output logic        misalign_err,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7,
    output logic [31:0] pc,
    output logic [31:0] pc_cur
);

    localparam int c_CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_complete;
    logic               w_timeout;

    logic [31:0]        r_pc;
    logic [31:0]        r_pc_cur;
    logic [31:0]        r_ir;
    logic               r_ir_valid;
    logic               r_fetch_err;
    logic               r_misalign;
    logic               r_pend_vld;
    logic [31:0]        r_pend_pc;
    logic [c_CNT_W-1:0] r_cnt;

    logic [31:0]        w_redir_tgt;
    logic               w_pend_vld;
    logic [31:0]        w_pend_tgt;

    // Redirect targets are always word aligned; a redirect arriving on the
    // same edge as completion/timeout counts as the latest pending write.
    assign w_redir_tgt = {pc_wr_data[31:2], 2'b00};
    assign w_pend_vld  = pc_wr_en | r_pend_vld;
    assign w_pend_tgt  = pc_wr_en ? w_redir_tgt : r_pend_pc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and completion/timeout strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fetch_en) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    if (mem_rvalid) begin
                        w_complete  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // PC, IR, pending redirect and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_pc_cur    <= RESET_PC;
            r_ir        <= NOP_INSTR;
            r_ir_valid  <= 1'b0;
            r_fetch_err <= 1'b0;
            r_misalign  <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_pend_pc   <= 32'h0;
        end else begin
            r_ir_valid  <= w_complete;
            r_fetch_err <= w_timeout;
            if (pc_wr_en && (pc_wr_data[1:0] != 2'b00)) begin
                r_misalign <= 1'b1;
            end
            if (r_state == S_IDLE) begin
                // Immediate redirect; a fetch started this edge uses it.
                if (pc_wr_en) begin
                    r_pc <= w_redir_tgt;
                end
            end else if (w_complete) begin
                r_ir       <= mem_rdata;
                r_pc_cur   <= r_pc;
                r_pc       <= w_pend_vld ? w_pend_tgt : (r_pc + 32'd4);
                r_pend_vld <= 1'b0;
            end else if (w_timeout) begin
                if (w_pend_vld) begin
                    r_pc <= w_pend_tgt;
                end
                r_pend_vld <= 1'b0;
            end else if (pc_wr_en) begin
                r_pend_vld <= 1'b1;
                r_pend_pc  <= w_redir_tgt;
            end
        end
    end

    // WAIT-cycle counter, cleared while the request is outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_REQ) begin
            r_cnt <= '0;
        end else if ((r_state == S_WAIT) && !mem_rvalid && !w_timeout) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign mem_req      = (r_state == S_REQ);
    assign busy         = (r_state != S_IDLE);
    assign mem_addr     = r_pc;
    assign ir_valid     = r_ir_valid;
    assign fetch_err    = r_fetch_err;
    assign misalign_err = r_misalign;
    assign instr        = r_ir;
    assign opcode       = r_ir[6:0];
    assign rd           = r_ir[11:7];
    assign funct3       = r_ir[14:12];
    assign rs1          = r_ir[19:15];
    assign rs2          = r_ir[24:20];
    assign funct7       = r_ir[31:25];
    assign pc           = r_pc;
    assign pc_cur       = r_pc_cur;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. Table-driven fetches
//               plus hand sequences; IR results go through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en, pc_wr_en, mem_gnt, mem_rvalid;
    logic [31:0] pc_wr_data, mem_rdata;
    logic        mem_req, busy, ir_valid, fetch_err, misalign_err;
    logic [31:0] mem_addr, instr, pc, pc_cur;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;

    // Second instance with a top-of-memory reset PC to observe wraparound.
    logic        w2_req, w2_busy, w2_irv, w2_ferr, w2_mis;
    logic [31:0] w2_addr, w2_instr, w2_pc, w2_pc_cur;
    logic [6:0]  w2_opc, w2_f7;
    logic [4:0]  w2_rd, w2_rs1, w2_rs2;
    logic [2:0]  w2_f3;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc_wr_en(pc_wr_en),
        .pc_wr_data(pc_wr_data), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .ir_valid(ir_valid), .fetch_err(fetch_err),
        .misalign_err(misalign_err), .instr(instr), .opcode(opcode), .rd(rd),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7), .pc(pc),
        .pc_cur(pc_cur)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc_wr_en(pc_wr_en),
        .pc_wr_data(pc_wr_data), .mem_req(w2_req), .mem_addr(w2_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(w2_busy), .ir_valid(w2_irv), .fetch_err(w2_ferr),
        .misalign_err(w2_mis), .instr(w2_instr), .opcode(w2_opc), .rd(w2_rd),
        .funct3(w2_f3), .rs1(w2_rs1), .rs2(w2_rs2), .funct7(w2_f7), .pc(w2_pc),
        .pc_cur(w2_pc_cur)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc_cur;
        logic [31:0] pc_nxt;
    } exp_t;

    typedef struct {
        logic [31:0] rdata;
        int          gdly;
        int          rdly;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        vecs[4];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ir;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every IR update against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && ir_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ir_valid: got instr %h expected no update", instr);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_instr", instr, mon_e.instr);
                chk("sb_pc_cur", pc_cur, mon_e.pc_cur);
                chk("sb_pc_next", pc, mon_e.pc_nxt);
                chk("sb_opcode", {25'h0, opcode}, {25'h0, mon_e.instr[6:0]});
                chk("sb_funct7", {25'h0, funct7}, {25'h0, mon_e.instr[31:25]});
            end
        end
    end

    // One fetch from IDLE: gdly REQ cycles without grant, then grant;
    // rdly WAIT cycles without rvalid (0 = rvalid with the grant).
    task automatic do_fetch(input logic [31:0] rdata, input int gdly, input int rdly);
        exp_t e;
        int   nreq;
        e.instr  = rdata;
        e.pc_cur = m_pc;
        e.pc_nxt = m_pc + 32'd4;
        sb.push_back(e);
        mem_rdata = rdata;
        fetch_en  = 1'b1;
        tick();
        fetch_en = 1'b0;
        nreq = 0;
        for (int k = 0; k < gdly; k++) begin
            if (mem_req) nreq++;
            chk("addr_stable", mem_addr, m_pc);
            tick();
        end
        if (mem_req) nreq++;
        mem_gnt    = 1'b1;
        mem_rvalid = (rdly == 0);
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        chk("req_cycles", nreq, gdly + 1);
        if (rdly > 0) begin
            chk("req_dropped", {31'h0, mem_req}, 32'h0);
            for (int k = 0; k < rdly; k++) tick();
            mem_rvalid = 1'b1;
            tick();
            mem_rvalid = 1'b0;
        end
        chk("ir_valid_hi", {31'h0, ir_valid}, 32'h1);
        chk("busy_done", {31'h0, busy}, 32'h0);
        m_pc = m_pc + 32'd4;
        m_ir = rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0513, 0, 0, 7'h13, 5'd10, 3'd0, 5'd0,  5'd0,  7'h00};
        vecs[1] = '{32'h00C5_8633, 3, 1, 7'h33, 5'd12, 3'd0, 5'd11, 5'd12, 7'h00};
        vecs[2] = '{32'h4020_8133, 1, 0, 7'h33, 5'd2,  3'd0, 5'd1,  5'd2,  7'h20};
        vecs[3] = '{32'h0002_A103, 0, 4, 7'h03, 5'd2,  3'd2, 5'd5,  5'd0,  7'h00};

        rst = 1'b1; fetch_en = 1'b0; pc_wr_en = 1'b0; pc_wr_data = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        m_pc = 32'h0; m_ir = c_NOP;
        tick(); tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_cur", pc_cur, 32'h0);
        chk("rst_instr", instr, c_NOP);
        chk("rst_flags", {27'h0, mem_req, busy, ir_valid, fetch_err, misalign_err}, 32'h0);
        chk("rst_pc2", w2_pc, 32'hFFFF_FFFC);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            do_fetch(vecs[i].rdata, vecs[i].gdly, vecs[i].rdly);
            chk("vec_opcode", {25'h0, opcode}, {25'h0, vecs[i].opc});
            chk("vec_rd", {27'h0, rd}, {27'h0, vecs[i].rd});
            chk("vec_funct3", {29'h0, funct3}, {29'h0, vecs[i].f3});
            chk("vec_rs1", {27'h0, rs1}, {27'h0, vecs[i].rs1});
            chk("vec_rs2", {27'h0, rs2}, {27'h0, vecs[i].rs2});
            chk("vec_funct7", {25'h0, funct7}, {25'h0, vecs[i].f7});
            if (i == 0) begin
                chk("wrap_pc", w2_pc, 32'h0);
                chk("wrap_pc_cur", w2_pc_cur, 32'hFFFF_FFFC);
            end
            tick();
            chk("ir_pulse", {31'h0, ir_valid}, 32'h0);
        end

        // Two redirects during WAIT: the last one wins at completion.
        sb.push_back('{32'h0010_0093, m_pc, 32'h100});
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
        pc_wr_en = 1'b1; pc_wr_data = 32'h80; tick();
        pc_wr_data = 32'h100; tick();
        pc_wr_en = 1'b0;
        chk("pend_not_applied", pc, m_pc);
        chk("pend_busy", {31'h0, busy}, 32'h1);
        mem_rvalid = 1'b1; mem_rdata = 32'h0010_0093; tick(); mem_rvalid = 1'b0;
        chk("redir_pc", pc, 32'h100);
        chk("redir_pc_cur", pc_cur, m_pc);
        m_pc = 32'h100; m_ir = 32'h0010_0093;
        tick();

        // Timeout: 16 WAIT cycles without rvalid.
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("to_still_busy", {30'h0, busy, fetch_err}, 32'h2);
        end
        tick();
        chk("to_fetch_err", {31'h0, fetch_err}, 32'h1);
        chk("to_busy", {31'h0, busy}, 32'h0);
        chk("to_instr", instr, m_ir);
        chk("to_pc", pc, m_pc);
        // Late rvalid/gnt in IDLE must be ignored.
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0; tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk("to_err_pulse", {31'h0, fetch_err}, 32'h0);
        chk("idle_rvalid_ign", {30'h0, ir_valid, busy}, 32'h0);
        chk("idle_instr", instr, m_ir);

        // Redirect and fetch_en together; fetch_en held while busy.
        sb.push_back('{32'h00A0_0113, 32'h40, 32'h44});
        fetch_en = 1'b1; pc_wr_en = 1'b1; pc_wr_data = 32'h40; tick();
        pc_wr_en = 1'b0;
        chk("both_addr", mem_addr, 32'h40);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h00A0_0113; tick();
        fetch_en = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk("both_irv", {31'h0, ir_valid}, 32'h1);
        tick();
        chk("busy_fetch_ign", {31'h0, busy}, 32'h0);
        m_pc = 32'h44; m_ir = 32'h00A0_0113;

        // Misaligned redirect in IDLE.
        pc_wr_en = 1'b1; pc_wr_data = 32'h0000_0102; tick(); pc_wr_en = 1'b0;
        chk("mis_set", {31'h0, misalign_err}, 32'h1);
        chk("mis_pc", pc, 32'h100);
        m_pc = 32'h100;
        tick();
        do_fetch(32'h0000_0513, 1, 0);
        tick();
        chk("mis_sticky", {31'h0, misalign_err}, 32'h1);

        // Reset during WAIT, then a late rvalid.
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; tick(); mem_rvalid = 1'b0;
        chk("rstw_instr", instr, c_NOP);
        chk("rstw_flags", {28'h0, ir_valid, busy, misalign_err, fetch_err}, 32'h0);
        chk("rstw_pc", pc, 32'h0);
        chk("rstw_pc_cur", pc_cur, 32'h0);
        chk("rstw_pc2", w2_pc, 32'hFFFF_FFFC);
        tick(); tick();
        chk("sb_empty", sb.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
